// File: rtl/sample_vector_gatherer_pkg.sv
// Shared types and helpers for the sample vector gatherer.
package gather_pkg;

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      STALL = 1'b1
   } gather_state_e;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sample_vector_gatherer_if.sv
// Sample stream in, gathered vector out; slave is the gatherer's view.
interface sample_vector_gatherer_if
   import gather_pkg::*;
#(
   parameter int NUM_INPUT = 8,
   parameter int WIDTH_IN  = 16,
   parameter int CNT_W     = cnt_width(NUM_INPUT)
);
   logic                                s_valid;
   logic                                s_ready;
   logic [WIDTH_IN-1:0]                 s_data;
   logic                                s_mask;
   logic                                s_last;
   logic                                m_valid;
   logic                                m_ready;
   logic [NUM_INPUT-1:0][WIDTH_IN-1:0]  m_data;
   logic [NUM_INPUT-1:0]                m_enable;
   logic [CNT_W-1:0]                    m_count;

   modport master (
      output s_valid, s_data, s_mask, s_last, m_ready,
      input  s_ready, m_valid, m_data, m_enable, m_count
   );

   modport slave (
      input  s_valid, s_data, s_mask, s_last, m_ready,
      output s_ready, m_valid, m_data, m_enable, m_count
   );
endinterface

// File: rtl/sample_vector_gatherer_vector_slot_bank.sv
// Slot register bank with per-slot enable bits: clear beats bulk load beats indexed write.
module vector_slot_bank
   import gather_pkg::*;
#(
   parameter int NUM_INPUT = 8,
   parameter int WIDTH_IN  = 16,
   parameter int IDX_W     = cnt_width(NUM_INPUT)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               clr,
   input  logic                               wr_en,
   input  logic [IDX_W-1:0]                   wr_idx,
   input  logic [WIDTH_IN-1:0]                wr_data,
   input  logic                               wr_enable,
   input  logic                               load_en,
   input  logic [NUM_INPUT-1:0][WIDTH_IN-1:0] load_data,
   input  logic [NUM_INPUT-1:0]               load_enable,
   output logic [NUM_INPUT-1:0][WIDTH_IN-1:0] data,
   output logic [NUM_INPUT-1:0]               enable
);
   logic [NUM_INPUT-1:0][WIDTH_IN-1:0] data_q, data_d;
   logic [NUM_INPUT-1:0]               enable_q, enable_d;

   // Next bank contents
   always_comb begin
      data_d   = data_q;
      enable_d = enable_q;
      if (clr) begin
         data_d   = '0;
         enable_d = '0;
      end else if (load_en) begin
         data_d   = load_data;
         enable_d = load_enable;
      end else if (wr_en) begin
         for (int i = 0; i < NUM_INPUT; i++) begin
            if (wr_idx == IDX_W'(i)) begin
               data_d[i]   = wr_data;
               enable_d[i] = wr_enable;
            end else begin
               data_d[i]   = data_q[i];
               enable_d[i] = enable_q[i];
            end
         end
      end else begin
         data_d   = data_q;
         enable_d = enable_q;
      end
   end

   // Bank registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q   <= '0;
         enable_q <= '0;
      end else begin
         data_q   <= data_d;
         enable_q <= enable_d;
      end
   end

   assign data   = data_q;
   assign enable = enable_q;
endmodule

// File: rtl/sample_vector_gatherer.sv
// Gathers a serial sample stream into NUM_INPUT-wide vectors with a slot enable mask.
// A fill bank collects the next frame while the output bank is presented downstream.
module sample_vector_gatherer
   import gather_pkg::*;
#(
   parameter int NUM_INPUT   = 8,
   parameter int WIDTH_IN    = 16,
   parameter bit ZERO_MASKED = 1'b1
) (
   input logic                    clk,
   input logic                    rst_n,
   input logic                    ena,
   sample_vector_gatherer_if.slave bus
);
   localparam int CNT_W = cnt_width(NUM_INPUT);

   gather_state_e                      state_q, state_d;
   logic [CNT_W-1:0]                   idx_q, idx_d;
   logic [CNT_W-1:0]                   count_q, count_d;
   logic                               m_valid_q, m_valid_d;
   logic                               s_ready_q, s_ready_d;
   logic                               in_s, out_s, out_free_s, close_s;
   logic                               fill_wr_s, fill_clr_s, out_load_s;
   logic [WIDTH_IN-1:0]                sample_s;
   logic [NUM_INPUT-1:0][WIDTH_IN-1:0] fill_data_s, out_data_s, merged_data_s;
   logic [NUM_INPUT-1:0]               fill_en_s, out_en_s, merged_en_s;

   assign bus.s_ready  = s_ready_q & ena;
   assign bus.m_valid  = m_valid_q & ena;
   assign bus.m_data   = out_data_s;
   assign bus.m_enable = out_en_s;
   assign bus.m_count  = count_q;

   assign in_s       = bus.s_valid & bus.s_ready;
   assign out_s      = bus.m_valid & bus.m_ready;
   assign out_free_s = ena & (~m_valid_q | bus.m_ready);
   assign sample_s   = (ZERO_MASKED && !bus.s_mask) ? '0 : bus.s_data;

   // Closing sample bypasses the fill bank so the vector lands on m_* at the same edge
   always_comb begin
      merged_data_s = fill_data_s;
      merged_en_s   = fill_en_s;
      for (int i = 0; i < NUM_INPUT; i++) begin
         if (in_s && (idx_q == CNT_W'(i))) begin
            merged_data_s[i] = sample_s;
            merged_en_s[i]   = bus.s_mask;
         end else begin
            merged_data_s[i] = fill_data_s[i];
            merged_en_s[i]   = fill_en_s[i];
         end
      end
   end

   // Control FSM, fill index and handshake next-state
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      count_d    = count_q;
      m_valid_d  = m_valid_q;
      fill_wr_s  = 1'b0;
      fill_clr_s = 1'b0;
      out_load_s = 1'b0;
      close_s    = 1'b0;
      if (ena) begin
         case (state_q)
            FILL: begin
               if (out_s) begin
                  m_valid_d = 1'b0;
               end else begin
                  m_valid_d = m_valid_q;
               end
               if (in_s) begin
                  close_s = (idx_q == CNT_W'(NUM_INPUT - 1)) | bus.s_last;
                  if (close_s && out_free_s) begin
                     out_load_s = 1'b1;
                     fill_clr_s = 1'b1;
                     m_valid_d  = 1'b1;
                     count_d    = idx_q + CNT_W'(1);
                     idx_d      = '0;
                  end else if (close_s) begin
                     fill_wr_s = 1'b1;
                     idx_d     = idx_q + CNT_W'(1);
                     state_d   = STALL;
                  end else begin
                     fill_wr_s = 1'b1;
                     idx_d     = idx_q + CNT_W'(1);
                  end
               end else begin
                  idx_d = idx_q;
               end
            end
            STALL: begin
               if (out_free_s) begin
                  out_load_s = 1'b1;
                  fill_clr_s = 1'b1;
                  m_valid_d  = 1'b1;
                  count_d    = idx_q;
                  idx_d      = '0;
                  state_d    = FILL;
               end else begin
                  state_d = STALL;
               end
            end
            default: begin
               state_d = FILL;
               idx_d   = '0;
            end
         endcase
         s_ready_d = (state_d == FILL);
      end else begin
         s_ready_d = s_ready_q;
      end
   end

   // Control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FILL;
         idx_q     <= '0;
         count_q   <= '0;
         m_valid_q <= 1'b0;
         s_ready_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         count_q   <= count_d;
         m_valid_q <= m_valid_d;
         s_ready_q <= s_ready_d;
      end
   end

   vector_slot_bank #(.NUM_INPUT(NUM_INPUT), .WIDTH_IN(WIDTH_IN), .IDX_W(CNT_W)) u_fill_bank (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (fill_clr_s),
      .wr_en       (fill_wr_s),
      .wr_idx      (idx_q),
      .wr_data     (sample_s),
      .wr_enable   (bus.s_mask),
      .load_en     (1'b0),
      .load_data   ('0),
      .load_enable ('0),
      .data        (fill_data_s),
      .enable      (fill_en_s)
   );

   vector_slot_bank #(.NUM_INPUT(NUM_INPUT), .WIDTH_IN(WIDTH_IN), .IDX_W(CNT_W)) u_out_bank (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (1'b0),
      .wr_en       (1'b0),
      .wr_idx      ('0),
      .wr_data     ('0),
      .wr_enable   (1'b0),
      .load_en     (out_load_s),
      .load_data   (merged_data_s),
      .load_enable (merged_en_s),
      .data        (out_data_s),
      .enable      (out_en_s)
   );
endmodule

// File: tb/tb_sample_vector_gatherer.sv
// Random and directed stimulus against a frame-queue reference model; two DUTs cover both masking modes.
module tb_sample_vector_gatherer;
   localparam int N = 8;
   localparam int W = 16;

   typedef struct {
      logic [127:0] d1;
      logic [127:0] d0;
      logic [7:0]   en;
      int           cnt;
   } frame_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ena = 1'b1;
   logic s_valid_t = 1'b0, s_mask_t = 1'b0, s_last_t = 1'b0, m_ready_t = 1'b0;
   logic [W-1:0] s_data_t = 16'd0;

   int n_checks = 0;
   int n_errors = 0;

   frame_t q[$];
   frame_t cur, last_f, f;
   bit     armed;
   bit     rand_on;

   sample_vector_gatherer_if #(.NUM_INPUT(N), .WIDTH_IN(W)) bus0 ();
   sample_vector_gatherer_if #(.NUM_INPUT(N), .WIDTH_IN(W)) bus1 ();

   assign bus0.s_valid = s_valid_t;
   assign bus0.s_data  = s_data_t;
   assign bus0.s_mask  = s_mask_t;
   assign bus0.s_last  = s_last_t;
   assign bus0.m_ready = m_ready_t;
   assign bus1.s_valid = s_valid_t;
   assign bus1.s_data  = s_data_t;
   assign bus1.s_mask  = s_mask_t;
   assign bus1.s_last  = s_last_t;
   assign bus1.m_ready = m_ready_t;

   sample_vector_gatherer #(.NUM_INPUT(N), .WIDTH_IN(W), .ZERO_MASKED(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus0));
   sample_vector_gatherer #(.NUM_INPUT(N), .WIDTH_IN(W), .ZERO_MASKED(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus1));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic frame_t empty_frame();
      frame_t e;
      e.d1 = 128'd0; e.d0 = 128'd0; e.en = 8'd0; e.cnt = 0;
      return e;
   endfunction

   // Reference model: outputs checked each negedge, then the upcoming edge's transfers are applied
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         cur    = empty_frame();
         last_f = empty_frame();
         armed  = 1'b0;
         check("rst_m_valid", 128'(bus0.m_valid), 128'd0);
         check("rst_s_ready", 128'(bus0.s_ready), 128'd0);
         check("rst_m_data", bus0.m_data, 128'd0);
         check("rst_m_count", 128'(bus0.m_count), 128'd0);
      end else begin
         bit exp_mv, exp_sr;
         exp_mv = ena && (q.size() > 0);
         exp_sr = ena && armed && (q.size() < 2);
         f = (q.size() > 0) ? q[0] : last_f;
         check("m_valid", 128'(bus0.m_valid), 128'(exp_mv));
         check("s_ready", 128'(bus0.s_ready), 128'(exp_sr));
         check("m_data_zm1", bus0.m_data, f.d1);
         check("m_data_zm0", bus1.m_data, f.d0);
         check("m_enable", 128'(bus0.m_enable), 128'(f.en));
         check("m_count", 128'(bus0.m_count), 128'(f.cnt));
         if (ena) begin
            if (exp_mv && m_ready_t) last_f = q.pop_front();
            if (s_valid_t && exp_sr) begin
               cur.d1[cur.cnt*W +: W] = s_mask_t ? s_data_t : 16'd0;
               cur.d0[cur.cnt*W +: W] = s_data_t;
               cur.en[cur.cnt]        = s_mask_t;
               cur.cnt++;
               if (cur.cnt == N || s_last_t) begin
                  q.push_back(cur);
                  cur = empty_frame();
               end
            end
            armed = 1'b1;
         end
      end
   end

   task automatic send(input logic [W-1:0] d, input logic m, input logic l);
      bit acc;
      acc = 1'b0;
      s_valid_t = 1'b1; s_data_t = d; s_mask_t = m; s_last_t = l;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (bus0.s_ready) begin
            acc = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      s_valid_t = 1'b0; s_last_t = 1'b0;
      if (!acc) check("send_timeout", 128'd0, 128'd1);
   endtask

   initial begin
      logic [127:0] e;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      m_ready_t = 1'b1;
      @(posedge clk); #1;

      // full frame 1..8
      for (int i = 0; i < N; i++) send(16'(i + 1), 1'b1, 1'b0);
      for (int i = 0; i < N; i++) e[i*W +: W] = 16'(i + 1);
      check("t1_valid", 128'(bus0.m_valid), 128'd1);
      check("t1_data", bus0.m_data, e);
      check("t1_enable", 128'(bus0.m_enable), 128'hFF);
      check("t1_count", 128'(bus0.m_count), 128'd8);

      // short frame closed by s_last
      send(16'd5, 1'b1, 1'b0); send(16'd6, 1'b1, 1'b0); send(16'd7, 1'b1, 1'b1);
      e = 128'd0; e[15:0] = 16'd5; e[31:16] = 16'd6; e[47:32] = 16'd7;
      check("t2_data", bus0.m_data, e);
      check("t2_enable", 128'(bus0.m_enable), 128'h07);
      check("t2_count", 128'(bus0.m_count), 128'd3);

      // alternating mask
      for (int i = 0; i < N; i++) send(16'd10, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
      e = 128'd0;
      for (int i = 0; i < N; i += 2) e[i*W +: W] = 16'd10;
      check("t3_zm1_data", bus0.m_data, e);
      check("t3_enable", 128'(bus0.m_enable), 128'h55);
      for (int i = 0; i < N; i++) e[i*W +: W] = 16'd10;
      check("t3_zm0_data", bus1.m_data, e);

      // back-pressure: two frames, second held in the fill bank
      @(posedge clk); #1 m_ready_t = 1'b0;
      for (int i = 0; i < 2 * N; i++) send(16'(100 + i), 1'b1, 1'b0);
      check("t4_stall_ready", 128'(bus0.s_ready), 128'd0);
      check("t4_frame1_slot0", 128'(bus0.m_data[0]), 128'd100);
      repeat (4) @(posedge clk);
      #1 m_ready_t = 1'b1;
      @(posedge clk); #1;
      check("t4_frame2_slot0", 128'(bus0.m_data[0]), 128'd108);
      repeat (3) @(posedge clk); #1;

      // clock-enable freeze mid-frame with a vector pending
      m_ready_t = 1'b0;
      for (int i = 0; i < N; i++) send(16'(300 + i), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) send(16'(400 + i), 1'b1, 1'b0);
      fork
         send(16'd403, 1'b1, 1'b0);
         begin
            ena = 1'b0;
            repeat (2) @(posedge clk); #1;
            check("t5_ena_ready", 128'(bus0.s_ready), 128'd0);
            check("t5_ena_valid", 128'(bus0.m_valid), 128'd0);
            repeat (3) @(posedge clk); #1;
            ena = 1'b1;
         end
      join
      m_ready_t = 1'b1;
      for (int i = 4; i < N; i++) send(16'(400 + i), 1'b1, 1'b0);
      check("t5_resume_slot3", 128'(bus0.m_data[3]), 128'd403);
      repeat (3) @(posedge clk); #1;

      // reset mid-frame
      for (int i = 0; i < 4; i++) send(16'(500 + i), 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 128'(bus0.m_valid), 128'd0);
      check("t6_rst_ready", 128'(bus0.s_ready), 128'd0);
      check("t6_rst_data", bus0.m_data, 128'd0);
      repeat (2) @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < N; i++) send(16'(200 + i), 1'b1, 1'b0);
      check("t6_clean_slot0", 128'(bus0.m_data[0]), 128'd200);
      check("t6_clean_count", 128'(bus0.m_count), 128'd8);

      // randomized stream with random back-pressure and enable drops
      rand_on = 1'b1;
      fork
         begin
            for (int k = 0; k < 300; k++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #0 send(16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
            end
            rand_on = 1'b0;
         end
         begin
            while (rand_on) begin
               @(posedge clk); #1;
               m_ready_t = ($urandom_range(0, 3) != 0);
               ena       = ($urandom_range(0, 15) != 0);
            end
         end
      join
      ena = 1'b1; m_ready_t = 1'b1;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (q.size() == 0) break;
      end
      check("drain", 128'(q.size()), 128'd0);
      @(posedge clk); #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
